// File: rtl/nibble_adder_seq_pkg.sv
// Package for nibble_adder_seq: state type, nibble width and the signed
// overflow helper shared by the sequencer.
package nibble_adder_seq_pkg;
  `include "nibble_adder_seq_defs.sv"

  localparam int NIBBLE_W = `NAS_NIBBLE_W;

  typedef enum logic [1:0] {
    S_IDLE = `NAS_S_IDLE,
    S_RUN  = `NAS_S_RUN,
    S_DONE = `NAS_S_DONE
  } state_e;

  // Two's-complement overflow: operands agree in sign, result does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction
endpackage

// File: rtl/nibble_adder_seq_if.sv
// Operand/result bus of nibble_adder_seq. The optional sub signal exists only
// when NIBBLE_ADDER_SEQ_SUB_EN is defined.
interface nibble_adder_seq_if
  import nibble_adder_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) ();
  localparam int W = NIBBLE_W * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
`ifdef NIBBLE_ADDER_SEQ_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  modport master (
`ifdef NIBBLE_ADDER_SEQ_SUB_EN
    output sub,
`endif
    output in_valid, op_a, op_b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
`ifdef NIBBLE_ADDER_SEQ_SUB_EN
    input  sub,
`endif
    input  in_valid, op_a, op_b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/nibble_adder_seq_addition.sv
// The 4-bit adder cell reused once per nibble by the sequencer.
module addition
  import nibble_adder_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                carry_in_i,
  output logic [NIBBLE_W-1:0] sum_o,
  output logic                carry_out_o
);
  assign {carry_out_o, sum_o} = {1'b0, a_i} + {1'b0, b_i}
                              + {{NIBBLE_W{1'b0}}, carry_in_i};
endmodule

// File: rtl/nibble_adder_seq_defs.sv
// Shared definitions for the nibble-serial adder: state encodings, nibble
// width and the nibble-index width rule. Guarded so it may be included from
// several files of the same compilation unit.
`ifndef NIBBLE_ADDER_SEQ_DEFS_SV
`define NIBBLE_ADDER_SEQ_DEFS_SV

`define NAS_S_IDLE   2'd0
`define NAS_S_RUN    2'd1
`define NAS_S_DONE   2'd2
`define NAS_NIBBLE_W 4
// Index width: clog2 of the nibble count, never narrower than one bit.
`define NAS_IDX_W(n) (((n) > 1) ? $clog2(n) : 1)

`endif

// File: rtl/nibble_adder_seq.sv
// nibble_adder_seq: wide add performed one nibble per clock through a single
// 4-bit adder cell, LS nibble first, carry registered between nibbles.
// Optional subtract mode: define NIBBLE_ADDER_SEQ_SUB_EN.
`include "nibble_adder_seq_defs.sv"

module nibble_adder_seq
  import nibble_adder_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input logic               clk,
  input logic               rst_n,
  nibble_adder_seq_if.slave bus
);
  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = `NAS_IDX_W(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  state_e                              state_q, state_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]    a_q, a_d;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]    b_q, b_d;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]    sum_q, sum_d;
  logic                                carry_q, carry_d;
  logic                                cout_q, cout_d;
  logic                                ovf_q, ovf_d;

  logic [NIBBLE_W-1:0]                 cell_sum_s;
  logic                                cell_co_s;

  // The one arithmetic resource, fed with the nibble selected by idx.
  addition u_cell (
    .a_i         (a_q[idx_q]),
    .b_i         (b_q[idx_q]),
    .carry_in_i  (carry_q),
    .sum_o       (cell_sum_s),
    .carry_out_o (cell_co_s)
  );

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign bus.sum       = W'(sum_q);
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

  // State, operand, carry and result registers; reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state: capture in IDLE, one nibble per cycle in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d   = bus.op_a;
          idx_d = '0;
`ifdef NIBBLE_ADDER_SEQ_SUB_EN
          if (bus.sub) begin
            b_d     = ~bus.op_b;
            carry_d = 1'b1;
          end else begin
            b_d     = bus.op_b;
            carry_d = bus.cin;
          end
`else
          b_d     = bus.op_b;
          carry_d = bus.cin;
`endif
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sum_d[idx_q] = cell_sum_s;
        carry_d      = cell_co_s;
        if (idx_q == LAST_IDX) begin
          // Last nibble: its carry and MSB settle cout and signed overflow.
          idx_d   = '0;
          cout_d  = cell_co_s;
          ovf_d   = signed_ovf(a_q[NIBBLES-1][NIBBLE_W-1],
                               b_q[NIBBLES-1][NIBBLE_W-1],
                               cell_sum_s[NIBBLE_W-1]);
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + ONE_IDX;
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end
endmodule
